sram_multiport_ctrl: RTL and testbench

//  Arbitrated byte-wide access controller for a 16-bit async SRAM (IS61WV6416 class).

---
 rtl/sram_multiport_ctrl_pkg.sv | 25 ++
 rtl/sram_multiport_ctrl_rr_arbiter.sv | 52 +++++
 rtl/sram_multiport_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sram_multiport_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_multiport_ctrl_pkg.sv
// Shared types for the multi-port byte-wide SRAM controller:
// FSM state encoding, byte-lane and priority-mode constants, lane extract helper.
package sram_multiport_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    function automatic logic [7:0] lane_byte(
        input logic [15:0] word,
        input logic        lane
    );
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sram_multiport_ctrl_rr_arbiter.sv
// Combinational requester arbiter, round-robin or fixed priority.
// Ports: req (request vector), last (previous grant index) -> grant (one-hot), idx, any.
module sram_multiport_ctrl_rr_arbiter
    import sram_multiport_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PRIO_MODE = 0,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    logic             found;
    logic [IDX_W-1:0] cand;
    logic             unused_last;

    // Fixed mode ignores the pointer.
    assign unused_last = ^last;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        if (PRIO_MODE == PRIO_FIXED) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand = IDX_W'(i);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end else begin
            // Search starts one past the last winner.
            for (int i = 1; i <= NUM_PORTS; i++) begin
                cand = IDX_W'((int'(last) + i) % NUM_PORTS);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
        grant[idx] = found;
    end

    assign any = found;

endmodule

// File: rtl/sram_multiport_ctrl.sv
// N-port byte-wide access controller for a 16-bit async SRAM with wait states.
// Ports: clk/n_reset, per-port req_*/rsp_* handshake, busy, registered hw_* SRAM pad controls.
module sram_multiport_ctrl
    import sram_multiport_ctrl_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int HW_ADDR_W   = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int PRIO_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             n_reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*(HW_ADDR_W+1)-1:0] req_addr,
    input  logic [NUM_PORTS*8-1:0]           req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [7:0]                       rsp_rdata,
    output logic                             busy,
    output logic [HW_ADDR_W-1:0]             hw_address,
    output logic                             hw_n_cs,
    output logic                             hw_n_we,
    output logic                             hw_n_oe,
    output logic                             hw_n_ub,
    output logic                             hw_n_lb,
    input  logic [15:0]                      hw_data_in,
    output logic [15:0]                      hw_data_out,
    output logic                             hw_data_oe
);

    localparam int AW    = HW_ADDR_W + 1;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d, last_q, last_d, gnt_idx;
    logic                 wr_q, wr_d, lane_q, lane_d;
    logic [NUM_PORTS-1:0] gnt;
    logic                 gnt_any;

    logic [NUM_PORTS-1:0] ready_d, rsp_d;
    logic [7:0]           rdata_d;
    logic                 busy_d;
    logic [HW_ADDR_W-1:0] addr_d;
    logic                 n_cs_d, n_we_d, n_oe_d, n_ub_d, n_lb_d;
    logic [15:0]          dout_d;
    logic                 doe_d;

    logic [AW-1:0]        sel_addr;
    logic [7:0]           sel_wdata;
    logic                 sel_wr;

    sram_multiport_ctrl_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PRIO_MODE (PRIO_MODE),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_wdata = req_wdata[int'(gnt_idx)*8 +: 8];
    assign sel_wr    = req_write[gnt_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        wr_d    = wr_q;
        lane_d  = lane_q;
        ready_d = '0;
        rsp_d   = '0;
        rdata_d = rsp_rdata;
        addr_d  = hw_address;
        dout_d  = hw_data_out;
        n_cs_d  = 1'b1;
        n_we_d  = 1'b1;
        n_oe_d  = 1'b1;
        n_ub_d  = 1'b1;
        n_lb_d  = 1'b1;
        doe_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RECOVER: begin
                if (gnt_any) begin
                    state_d = ST_SETUP;
                    idx_d   = gnt_idx;
                    last_d  = gnt_idx;
                    wr_d    = sel_wr;
                    lane_d  = sel_addr[0];
                    cnt_d   = 4'(WAIT_CYCLES);
                    ready_d = gnt;
                    addr_d  = sel_addr[AW-1:1];
                    dout_d  = {sel_wdata, sel_wdata};
                    n_cs_d  = 1'b0;
                    n_oe_d  = sel_wr;
                    // Write data is driven for the whole SETUP; reads float the bus.
                    doe_d   = sel_wr;
                    n_lb_d  = (sel_addr[0] != LANE_LO);
                    n_ub_d  = (sel_addr[0] != LANE_HI);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                n_cs_d  = 1'b0;
                n_oe_d  = wr_q;
                n_we_d  = ~wr_q;
                doe_d   = wr_q;
                n_ub_d  = hw_n_ub;
                n_lb_d  = hw_n_lb;
            end
            ST_ACCESS: begin
                if (cnt_q > 4'd1) begin
                    cnt_d  = cnt_q - 4'd1;
                    n_cs_d = 1'b0;
                    n_oe_d = wr_q;
                    n_we_d = ~wr_q;
                    doe_d  = wr_q;
                    n_ub_d = hw_n_ub;
                    n_lb_d = hw_n_lb;
                end else begin
                    state_d       = ST_RECOVER;
                    // Keep driving write data one cycle past n_we rise.
                    doe_d         = wr_q;
                    rsp_d[idx_q]  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = lane_byte(hw_data_in, lane_q);
                    end
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            last_q      <= IDX_W'(NUM_PORTS - 1);
            wr_q        <= 1'b0;
            lane_q      <= 1'b0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            busy        <= 1'b0;
            hw_address  <= '0;
            hw_n_cs     <= 1'b1;
            hw_n_we     <= 1'b1;
            hw_n_oe     <= 1'b1;
            hw_n_ub     <= 1'b1;
            hw_n_lb     <= 1'b1;
            hw_data_out <= '0;
            hw_data_oe  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            lane_q      <= lane_d;
            req_ready   <= ready_d;
            rsp_valid   <= rsp_d;
            rsp_rdata   <= rdata_d;
            busy        <= busy_d;
            hw_address  <= addr_d;
            hw_n_cs     <= n_cs_d;
            hw_n_we     <= n_we_d;
            hw_n_oe     <= n_oe_d;
            hw_n_ub     <= n_ub_d;
            hw_n_lb     <= n_lb_d;
            hw_data_out <= dout_d;
            hw_data_oe  <= doe_d;
        end
    end

endmodule

// File: tb/tb_sram_multiport_ctrl.sv
// Directed bench for sram_multiport_ctrl: three instances (RR/WAIT=1, fixed/WAIT=1, RR/WAIT=3).
// Shared address/data/write inputs; each instance has its own req_valid vector.
module tb_sram_multiport_ctrl;

    localparam int AW = 17;

    logic            clk = 1'b0;
    logic            n_reset;
    logic [2:0]      va, vb, vc;
    logic [2:0]      req_write;
    logic [3*AW-1:0] req_addr;
    logic [23:0]     req_wdata;
    logic [15:0]     hw_data_in;

    logic [2:0]  rdy   [3];
    logic [2:0]  rsp   [3];
    logic [7:0]  rdata [3];
    logic        busy  [3];
    logic [15:0] haddr [3];
    logic [15:0] dout  [3];
    logic        ncs   [3];
    logic        nwe   [3];
    logic        noe   [3];
    logic        nub   [3];
    logic        nlb   [3];
    logic        doe   [3];

    int vecs = 0;
    int errs = 0;
    int xcnt = 0;

    always #5 clk = ~clk;

    sram_multiport_ctrl #(
        .NUM_PORTS(3), .HW_ADDR_W(16), .WAIT_CYCLES(1), .PRIO_MODE(0)
    ) u_a (
        .clk(clk), .n_reset(n_reset), .req_valid(va), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
        .rsp_valid(rsp[0]), .rsp_rdata(rdata[0]), .busy(busy[0]),
        .hw_address(haddr[0]), .hw_n_cs(ncs[0]), .hw_n_we(nwe[0]),
        .hw_n_oe(noe[0]), .hw_n_ub(nub[0]), .hw_n_lb(nlb[0]),
        .hw_data_in(hw_data_in), .hw_data_out(dout[0]), .hw_data_oe(doe[0])
    );

    sram_multiport_ctrl #(
        .NUM_PORTS(3), .HW_ADDR_W(16), .WAIT_CYCLES(1), .PRIO_MODE(1)
    ) u_b (
        .clk(clk), .n_reset(n_reset), .req_valid(vb), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
        .rsp_valid(rsp[1]), .rsp_rdata(rdata[1]), .busy(busy[1]),
        .hw_address(haddr[1]), .hw_n_cs(ncs[1]), .hw_n_we(nwe[1]),
        .hw_n_oe(noe[1]), .hw_n_ub(nub[1]), .hw_n_lb(nlb[1]),
        .hw_data_in(hw_data_in), .hw_data_out(dout[1]), .hw_data_oe(doe[1])
    );

    sram_multiport_ctrl #(
        .NUM_PORTS(3), .HW_ADDR_W(16), .WAIT_CYCLES(3), .PRIO_MODE(0)
    ) u_c (
        .clk(clk), .n_reset(n_reset), .req_valid(vc), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[2]),
        .rsp_valid(rsp[2]), .rsp_rdata(rdata[2]), .busy(busy[2]),
        .hw_address(haddr[2]), .hw_n_cs(ncs[2]), .hw_n_we(nwe[2]),
        .hw_n_oe(noe[2]), .hw_n_ub(nub[2]), .hw_n_lb(nlb[2]),
        .hw_data_in(hw_data_in), .hw_data_out(dout[2]), .hw_data_oe(doe[2])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if ($isunknown({haddr[d], dout[d], ncs[d], nwe[d], noe[d],
                            nub[d], nlb[d], doe[d]}))
                xcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grant_seq(input int d, input logic [11:0] exp);
        logic [2:0] g;
        int         n;
        string      tag;
        tag = (d == 0) ? "rr_grant" : "fixed_grant";
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (d == 0) va = 3'b111; else vb = 3'b111;
            n = 0;
            g = rdy[d];
            while (g == 3'b000 && n < 12) begin
                @(negedge clk);
                n++;
                g = rdy[d];
            end
            chk(tag, g, exp[11-3*k -: 3]);
            if (d == 0) va = va & ~g; else vb = vb & ~g;
        end
        @(negedge clk);
        va = '0;
        vb = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int         oe_cnt, rsp_at, wr_rsp_at, rd_rdy_at, rd_rsp_at;
        int         viol, coinc;
        logic       saw_rsp, su_doe, su_oe;
        logic [7:0] rd;

        n_reset    = 1'b0;
        va         = '0;
        vb         = '0;
        vc         = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        hw_data_in = '0;
        repeat (2) @(negedge clk);

        chk("rst_ncs", ncs[0], 1);
        chk("rst_nwe", nwe[0], 1);
        chk("rst_noe", noe[0], 1);
        chk("rst_nub_nlb", {nub[0], nlb[0]}, 2'b11);
        chk("rst_doe", doe[0], 0);
        chk("rst_addr", haddr[0], 0);
        chk("rst_dout", dout[0], 0);
        chk("rst_ready", rdy[0], 0);
        chk("rst_rsp", rsp[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_busy", busy[0], 0);
        n_reset = 1'b1;
        @(negedge clk);

        // Port 0 read of byte 0x00003, upper lane of word 1.
        req_addr[0 +: AW] = 17'h00003;
        req_write  = 3'b000;
        hw_data_in = 16'hA55A;
        va         = 3'b001;
        @(negedge clk);
        chk("rd_ready", rdy[0], 3'b001);
        chk("rd_addr", haddr[0], 16'h0001);
        chk("rd_lanes", {nub[0], nlb[0]}, 2'b01);
        chk("rd_setup_ctl", {ncs[0], noe[0], nwe[0], doe[0]}, 4'b0010);
        chk("rd_busy", busy[0], 1);
        va = '0;
        @(negedge clk);
        chk("rd_access_ctl", {ncs[0], noe[0], nwe[0]}, 3'b001);
        chk("rd_access_rsp", rsp[0], 0);
        @(negedge clk);
        chk("rd_rsp", rsp[0], 3'b001);
        chk("rd_rdata", rdata[0], 8'hA5);
        chk("rd_recover_ctl", {ncs[0], noe[0]}, 2'b11);
        @(negedge clk);
        chk("rd_idle_rsp", rsp[0], 0);
        chk("rd_idle_busy", busy[0], 0);

        // Port 1 write of 0x3C to byte 0x00004, lower lane of word 2.
        req_addr[AW +: AW] = 17'h00004;
        req_write       = 3'b010;
        req_wdata[15:8] = 8'h3C;
        va              = 3'b010;
        @(negedge clk);
        chk("wr_ready", rdy[0], 3'b010);
        chk("wr_addr", haddr[0], 16'h0002);
        chk("wr_dout", dout[0], 16'h3C3C);
        chk("wr_lanes", {nub[0], nlb[0]}, 2'b10);
        chk("wr_setup_ctl", {ncs[0], nwe[0], noe[0], doe[0]}, 4'b0111);
        va = '0;
        @(negedge clk);
        chk("wr_access_ctl", {ncs[0], nwe[0], noe[0], doe[0]}, 4'b0011);
        @(negedge clk);
        chk("wr_recover_ctl", {ncs[0], nwe[0], doe[0]}, 3'b111);
        chk("wr_rsp", rsp[0], 3'b010);
        @(negedge clk);
        chk("wr_hold_end", doe[0], 0);
        chk("wr_idle_busy", busy[0], 0);

        // Reset asserted while n_we is low.
        va = 3'b010;
        @(negedge clk);
        va = '0;
        @(negedge clk);
        chk("abort_pre_nwe", nwe[0], 0);
        #3 n_reset = 1'b0;
        #1;
        chk("abort_async_ctl", {ncs[0], nwe[0], doe[0]}, 3'b110);
        @(negedge clk);
        n_reset = 1'b1;
        saw_rsp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_rsp = saw_rsp | (|rsp[0]);
        end
        chk("abort_no_rsp", saw_rsp, 0);

        // All ports requesting continuously.
        req_write = 3'b000;
        grant_seq(0, {3'b001, 3'b010, 3'b100, 3'b001});
        grant_seq(1, {3'b001, 3'b001, 3'b001, 3'b001});

        // Three wait states, lower-lane read.
        req_addr[0 +: AW] = 17'h00002;
        req_write  = 3'b000;
        hw_data_in = 16'h1234;
        vc         = 3'b001;
        oe_cnt     = 0;
        rsp_at     = 0;
        rd         = '0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) vc = '0;
            if (!noe[2]) oe_cnt++;
            if (rsp[2] != 3'b000 && rsp_at == 0) begin
                rsp_at = i;
                rd     = rdata[2];
            end
        end
        chk("w3_oe_cycles", oe_cnt, 4);
        chk("w3_rsp_at", rsp_at, 5);
        chk("w3_rdata", rd, 8'h34);

        // Write on port 1 then read on port 0, both pending.
        req_addr[AW +: AW] = 17'h00006;
        req_addr[0 +: AW]  = 17'h00008;
        req_wdata[15:8]    = 8'h77;
        req_write          = 3'b010;
        hw_data_in         = 16'hBEEF;
        vc                 = 3'b011;
        wr_rsp_at = 0;
        rd_rdy_at = 0;
        rd_rsp_at = 0;
        viol      = 0;
        coinc     = 0;
        su_doe    = 1'b1;
        su_oe     = 1'b1;
        rd        = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy[2][0]) begin
                rd_rdy_at = i;
                su_doe    = doe[2];
                su_oe     = noe[2];
            end
            vc = vc & ~rdy[2];
            if (!noe[2] && doe[2]) viol++;
            if (!noe[2] && !nwe[2]) viol++;
            if (rdy[2] != 3'b000 && rsp[2] != 3'b000) coinc++;
            if (rsp[2][1]) wr_rsp_at = i;
            if (rsp[2][0]) begin
                rd_rsp_at = i;
                rd        = rdata[2];
            end
        end
        chk("wr_rd_wr_rsp_at", wr_rsp_at, 5);
        chk("wr_rd_rd_ready_at", rd_rdy_at, 6);
        chk("wr_rd_setup_doe", su_doe, 0);
        chk("wr_rd_setup_noe", su_oe, 0);
        chk("wr_rd_rd_rsp_at", rd_rsp_at, 10);
        chk("wr_rd_rdata", rd, 8'hEF);
        chk("wr_rd_oe_we_viol", viol, 0);
        chk("wr_rd_ready_rsp_coincide", coinc, 0);

        // Top byte address, port 2.
        req_addr[2*AW +: AW] = 17'h1FFFF;
        req_write  = 3'b000;
        hw_data_in = 16'hC396;
        va         = 3'b100;
        @(negedge clk);
        chk("max_ready", rdy[0], 3'b100);
        chk("max_addr", haddr[0], 16'hFFFF);
        chk("max_lanes", {nub[0], nlb[0]}, 2'b01);
        va = '0;
        @(negedge clk);
        @(negedge clk);
        chk("max_rsp", rsp[0], 3'b100);
        chk("max_rdata", rdata[0], 8'hC3);
        repeat (2) @(negedge clk);
        chk("no_x_on_pads", xcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
